// File: rtl/gpr_writeback_arbiter.sv
// Round-robin arbiter for the single GPR write port, with a registered write-back stage.
// Optional forwarding of the pending (registered, uncommitted) write: define GPR_WB_ARB_FWD_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef L2_REG_FILE_SIZE
`define L2_REG_FILE_SIZE 5
`endif

module gpr_writeback_arbiter #(
    parameter int num_req     = 3,
    parameter int l2_num_req  = 2,
    parameter int l2_num_regs = `L2_REG_FILE_SIZE
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [num_req-1:0]                i_req_valid,
    output logic [num_req-1:0]                o_req_ready,
    input  logic [num_req*l2_num_regs-1:0]    i_req_sel,
    input  logic [num_req*`WORD_SIZE-1:0]     i_req_data,
    input  logic                              i_stall,
    output logic                              o_load_gpr,
    output logic [l2_num_regs-1:0]            o_load_gpr_sel,
    output logic [`WORD_SIZE-1:0]             o_load_gpr_data,
    output logic [l2_num_req-1:0]             o_grant_id
`ifdef GPR_WB_ARB_FWD_EN
    ,
    input  logic [l2_num_regs-1:0]            i_fwd_A_sel,
    input  logic [l2_num_regs-1:0]            i_fwd_B_sel,
    output logic                              o_fwd_A_hit,
    output logic                              o_fwd_B_hit,
    output logic [`WORD_SIZE-1:0]             o_fwd_A_data,
    output logic [`WORD_SIZE-1:0]             o_fwd_B_data
`endif
);

    logic [l2_num_req-1:0]  rr_ptr;
    logic [l2_num_req-1:0]  win_idx;
    logic                   win_found;
    logic [l2_num_regs-1:0] win_sel;
    logic [`WORD_SIZE-1:0]  win_data;

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < num_req; i++) begin
            int j;
            j = int'(rr_ptr) + i;
            if (j >= num_req) j = j - num_req;
            if (!win_found && i_req_valid[j]) begin
                win_found = 1'b1;
                win_idx   = l2_num_req'(j);
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (!i_rst && !i_stall && win_found)
            o_req_ready[win_idx] = 1'b1;
    end

    always_comb begin
        win_sel  = '0;
        win_data = '0;
        for (int k = 0; k < num_req; k++) begin
            if (int'(win_idx) == k) begin
                win_sel  = i_req_sel[k*l2_num_regs +: l2_num_regs];
                win_data = i_req_data[k*`WORD_SIZE +: `WORD_SIZE];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_load_gpr      <= 1'b0;
            o_load_gpr_sel  <= '0;
            o_load_gpr_data <= '0;
            o_grant_id      <= '0;
            rr_ptr          <= '0;
        end else if (|o_req_ready) begin
            // r0 writes complete the handshake but never strobe the file.
            o_load_gpr      <= (win_sel != '0);
            o_load_gpr_sel  <= win_sel;
            o_load_gpr_data <= win_data;
            o_grant_id      <= win_idx;
            rr_ptr          <= (int'(win_idx) == num_req - 1) ? '0 : win_idx + 1'b1;
        end else begin
            o_load_gpr      <= 1'b0;
        end
    end

`ifdef GPR_WB_ARB_FWD_EN
    always_comb begin
        o_fwd_A_hit  = !i_rst && o_load_gpr && (i_fwd_A_sel == o_load_gpr_sel) && (i_fwd_A_sel != '0);
        o_fwd_B_hit  = !i_rst && o_load_gpr && (i_fwd_B_sel == o_load_gpr_sel) && (i_fwd_B_sel != '0);
        o_fwd_A_data = o_fwd_A_hit ? o_load_gpr_data : '0;
        o_fwd_B_data = o_fwd_B_hit ? o_load_gpr_data : '0;
    end
`endif

endmodule
